// File: rtl/tinyalu_pkg.sv
// Shared types for the parametrised tiny ALU: opcode and FSM state enums,
// plus a helper classifying which opcodes finish in a single EXEC cycle.
package tinyalu_pkg;

  typedef enum bit [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_SUB = 3'b101,
    OP_RSV = 3'b110,
    OP_RST = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL_WAIT,
    ST_DONE
  } state_t;

  function automatic logic is_single_cycle(input operation_t o);
    return (o == OP_ADD) || (o == OP_AND) || (o == OP_XOR) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Fixed-latency multiplier: full WIDTHxWIDTH product formed on the input edge,
// then carried down a MUL_STAGES-deep pipe in lockstep with a valid bit.
module tinyalu_mul_pipe #(
  parameter int WIDTH      = 8,
  parameter int MUL_STAGES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] product
);

  logic               valid_q [MUL_STAGES];
  logic [2*WIDTH-1:0] prod_q  [MUL_STAGES];

  // Only the valid bits need reset; stale data is never qualified.
  always_ff @(posedge clk) begin
    if (reset) valid_q[0] <= 1'b0;
    else       valid_q[0] <= in_valid;
    prod_q[0] <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  for (genvar gi = 1; gi < MUL_STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (reset) valid_q[gi] <= 1'b0;
      else       valid_q[gi] <= valid_q[gi-1];
      prod_q[gi] <= prod_q[gi-1];
    end
  end

  assign out_valid = valid_q[MUL_STAGES-1];
  assign product   = prod_q[MUL_STAGES-1];

endmodule

// File: rtl/tinyalu_param.sv
// Parametrised tiny ALU with start/done handshake and pipelined multiply.
// Define TINYALU_CARRY_EN to register the add-carry / sub-borrow flag.
module tinyalu_param
  import tinyalu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_STAGES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic [2*WIDTH-1:0] result,
  output logic               carry
);

  state_t             state_q;
  operation_t         op_q;
  operation_t         op_in;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic [2*WIDTH-1:0] alu_d;
  logic [2*WIDTH-1:0] result_q;
  logic [2*WIDTH-1:0] product;
  logic               done_q, busy_q;
  logic               accept, mul_valid;

  assign op_in  = operation_t'(op);
  assign accept = (state_q == ST_IDLE) && start;
  assign a_ext  = {{WIDTH{1'b0}}, a_q};
  assign b_ext  = {{WIDTH{1'b0}}, b_q};

  // Multiplier takes the raw inputs on the accept edge so latency is exact.
  tinyalu_mul_pipe #(
    .WIDTH      (WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept && (op_in == OP_MUL)),
    .a         (A),
    .b         (B),
    .out_valid (mul_valid),
    .product   (product)
  );

  always_comb begin
    alu_d = '0;
    case (op_q)
      OP_ADD:  alu_d = a_ext + b_ext;
      OP_SUB:  alu_d = a_ext - b_ext;
      OP_AND:  alu_d = a_ext & b_ext;
      OP_XOR:  alu_d = a_ext ^ b_ext;
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op_in;
            if (is_single_cycle(op_in))  state_q  <= ST_EXEC;
            else if (op_in == OP_MUL)    state_q  <= ST_MUL_WAIT;
            else if (op_in == OP_RST)    result_q <= '0;
          end
        end
        ST_EXEC: begin
          result_q <= alu_d;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_MUL_WAIT: begin
          if (mul_valid) begin
            result_q <= product;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            busy_q <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef TINYALU_CARRY_EN
  logic carry_q, carry_d, finish;

  assign finish = (state_q == ST_EXEC) || ((state_q == ST_MUL_WAIT) && mul_valid);

  always_comb begin
    carry_d = 1'b0;
    if (op_q == OP_ADD)      carry_d = alu_d[WIDTH];
    else if (op_q == OP_SUB) carry_d = (a_q < b_q);
  end

  always_ff @(posedge clk) begin
    if (reset)                          carry_q <= 1'b0;
    else if (accept && op_in == OP_RST) carry_q <= 1'b0;
    else if (finish)                    carry_q <= carry_d;
  end

  assign carry = carry_q;
`else
  assign carry = 1'b0;
`endif

  assign done   = done_q;
  assign busy   = busy_q;
  assign result = result_q;

endmodule

// File: tb/tb_tinyalu_param.sv
// Directed bench for tinyalu_param at WIDTH=8/MUL_STAGES=3 and WIDTH=16/MUL_STAGES=1,
// with an expected-result queue popped on each done pulse.
module tb_tinyalu_param;

`ifdef TINYALU_CARRY_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic        carry;
  } exp_t;

  logic        clk;
  logic        rst8, start8, done8, busy8, carry8;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic [15:0] res8;
  logic        rst16, start16, done16, busy16, carry16;
  logic [15:0] a16, b16;
  logic [2:0]  op16;
  logic [31:0] res16;

  logic        sel;
  logic        done_s, busy_s, carry_s;
  logic [31:0] res_s;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  tinyalu_param #(.WIDTH(8), .MUL_STAGES(3)) dut8 (
    .clk(clk), .reset(rst8), .A(a8), .B(b8), .op(op8), .start(start8),
    .done(done8), .busy(busy8), .result(res8), .carry(carry8)
  );

  tinyalu_param #(.WIDTH(16), .MUL_STAGES(1)) dut16 (
    .clk(clk), .reset(rst16), .A(a16), .B(b16), .op(op16), .start(start16),
    .done(done16), .busy(busy16), .result(res16), .carry(carry16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign done_s  = sel ? done16  : done8;
  assign busy_s  = sel ? busy16  : busy8;
  assign carry_s = sel ? carry16 : carry8;
  assign res_s   = sel ? res16   : {16'h0000, res8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start16 = v;
    else   start8  = v;
  endtask

  // Drive one request at the current negedge, then watch a bounded window.
  task automatic issue(input string tag, input bit s, input logic [2:0] o,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] er, input logic ec, input bit exp_done,
                       input int lat, input bit hold, input bit b2b);
    int   done_cnt = 0;
    int   done_at  = -1;
    int   busy_cnt = 0;
    int   last;
    exp_t e;
    last = b2b ? lat + 1 : lat + 3;
    sel = s;
    if (s) begin op16 = o; a16 = a; b16 = b; end
    else   begin op8 = o; a8 = a[7:0]; b8 = b[7:0]; end
    set_start(s, 1'b1);
    if (exp_done) sb.push_back('{res: er, carry: ec});
    @(posedge clk);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (done_s) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_result"}, res_s, e.res);
          chk({tag, "_carry"}, 32'(carry_s), 32'(e.carry));
        end
      end
      if (busy_s) busy_cnt++;
      if (c == 0) begin
        if (s) begin a16 = 16'($urandom); b16 = 16'($urandom); end
        else   begin a8 = 8'($urandom); b8 = 8'($urandom); end
        if (!hold) begin
          set_start(s, 1'b0);
          if (s) op16 = 3'($urandom);
          else   op8  = 3'($urandom);
        end
      end
      if (hold && c == lat + 1) set_start(s, 1'b0);
    end
    sb.delete();
    if (exp_done) begin
      chk({tag, "_done_cycle"}, 32'(done_at), 32'(lat));
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    end else begin
      chk({tag, "_no_done"}, 32'(done_cnt), 32'd0);
      chk({tag, "_no_busy"}, 32'(busy_cnt), 32'd0);
    end
    chk({tag, "_result_hold"}, res_s, er);
    chk({tag, "_carry_hold"}, 32'(carry_s), 32'(ec));
    $display("txn %s: op=%0d A=%h B=%h result=%h carry=%b done_at=%0d busy_cycles=%0d",
             tag, o, a, b, res_s, carry_s, done_at, busy_cnt);
  endtask

  initial begin
    int dcnt;
    sel = 1'b0;
    rst8 = 1'b1; rst16 = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; op8 = '0;
    a16 = '0; b16 = '0; op16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0; rst16 = 1'b0;
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_result8", {16'h0, res8}, 32'h0);
    chk("reset_carry8", 32'(carry8), 32'd0);
    chk("reset_done16", 32'(done16), 32'd0);
    chk("reset_busy16", 32'(busy16), 32'd0);
    chk("reset_result16", res16, 32'h0);

    // WIDTH=8, MUL_STAGES=3
    issue("add_ff_01", 1'b0, 3'b001, 16'hFF, 16'h01, 32'h0100, CARRY_ON, 1'b1, 1, 1'b0, 1'b0);
    issue("mul_ff_ff", 1'b0, 3'b100, 16'hFF, 16'hFF, 32'hFE01, 1'b0, 1'b1, 3, 1'b1, 1'b0);
    issue("sub_03_05", 1'b0, 3'b101, 16'h03, 16'h05, 32'hFFFE, CARRY_ON, 1'b1, 1, 1'b0, 1'b0);
    issue("sub_05_03", 1'b0, 3'b101, 16'h05, 16'h03, 32'h0002, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    issue("and_ca_0f", 1'b0, 3'b010, 16'hCA, 16'h0F, 32'h000A, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    issue("xor_ca_0f", 1'b0, 3'b011, 16'hCA, 16'h0F, 32'h00C5, 1'b0, 1'b1, 1, 1'b0, 1'b0);

    // Reset arrives one edge after a multiply is accepted.
    sel = 1'b0;
    a8 = 8'h10; b8 = 8'h10; op8 = 3'b100; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; rst8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_result", {16'h0, res8}, 32'h0);
    $display("txn abort_mul: A=10 B=10 reset at accept+1, result=%h dones=%0d", res8, dcnt);

    issue("add_01_01", 1'b0, 3'b001, 16'h01, 16'h01, 32'h0002, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    issue("add_02_03", 1'b0, 3'b001, 16'h02, 16'h03, 32'h0005, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    issue("noop_hold", 1'b0, 3'b000, 16'h77, 16'h88, 32'h0005, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    issue("rsv_hold",  1'b0, 3'b110, 16'h77, 16'h88, 32'h0005, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    issue("sub_carry", 1'b0, 3'b101, 16'h03, 16'h05, 32'hFFFE, CARRY_ON, 1'b1, 1, 1'b0, 1'b0);
    issue("rst_op",    1'b0, 3'b111, 16'h12, 16'h34, 32'h0000, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    issue("noop_after_rst", 1'b0, 3'b000, 16'h12, 16'h34, 32'h0000, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    // WIDTH=16, MUL_STAGES=1, back-to-back with one idle cycle
    issue("mul16_ffff", 1'b1, 3'b100, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    issue("and16_b2b",  1'b1, 3'b010, 16'hF0F0, 16'hFF00, 32'h0000F000, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    issue("xor16_b2b",  1'b1, 3'b011, 16'h1234, 16'h00FF, 32'h000012CB, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    issue("add16_carry", 1'b1, 3'b001, 16'hFFFF, 16'h0002, 32'h00010001, CARRY_ON, 1'b1, 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
